// File: rtl/prog_ctr_seq_if.sv
// Fetch-stage control bundle between the decoder/LUT side and the PC sequencer.
interface prog_ctr_seq_if #(
    parameter int unsigned D = 12
);
    logic           Start;
    logic           Halt;
    logic           Stall;
    logic           Jump;
    logic           JumpRel;
    logic           Call;
    logic           Ret;
    logic [3:0]     LutIdx;
    logic [3:0]     LutAddr;
    logic [D-1:0]   LutTarget;
    logic [D-1:0]   ProgCtr;
    logic           Running;
    logic           Done;
    logic           StackErr;

    // Decoder and branch-target LUT side
    modport master (
        output Start, Halt, Stall, Jump, JumpRel, Call, Ret, LutIdx, LutTarget,
        input  LutAddr, ProgCtr, Running, Done, StackErr
    );

    // Sequencer side
    modport slave (
        input  Start, Halt, Stall, Jump, JumpRel, Call, Ret, LutIdx, LutTarget,
        output LutAddr, ProgCtr, Running, Done, StackErr
    );
endinterface

// File: rtl/prog_ctr_seq.sv
// Program counter sequencer: start/halt control, branch via LUT, return stack.
module prog_ctr_seq #(
    parameter int unsigned   D        = 12,
    parameter int unsigned   STACK_D  = 4,
    parameter logic [D-1:0]  START_PC = '0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    prog_ctr_seq_if.slave bus
);
    localparam int unsigned SP_W  = $clog2(STACK_D + 1);
    localparam int unsigned IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [D-1:0]    pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic            running_q, done_q;
    logic            push;
    logic [D-1:0]    pc_inc;
    logic [SP_W-1:0] sp_dec;
    logic            stk_full, stk_empty;
    logic [D-1:0]    stack_q [STACK_D];

    // Zero-latency LUT lookup: index passes straight through
    assign bus.LutAddr  = bus.LutIdx;
    assign bus.ProgCtr  = pc_q;
    assign bus.Running  = running_q;
    assign bus.Done     = done_q;
    assign bus.StackErr = err_q;

    assign pc_inc    = pc_q + D'(1);
    assign sp_dec    = sp_q - SP_W'(1);
    assign stk_full  = (sp_q == SP_W'(STACK_D));
    assign stk_empty = (sp_q == '0);

    // Next state, next PC and stack control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    pc_d    = START_PC;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (!bus.Stall) begin
                    if (bus.Halt) begin
                        state_d = S_DONE;
                    end else if (bus.Ret) begin
                        if (!stk_empty) begin
                            sp_d = sp_dec;
                            pc_d = stack_q[IDX_W'(sp_dec)];
                        end else begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end
                    end else if (bus.Call) begin
                        if (!stk_full) begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                        pc_d = bus.LutTarget;
                    end else if (bus.Jump) begin
                        // Two's complement offset add falls out of plain D-bit wraparound
                        pc_d = bus.JumpRel ? (pc_q + bus.LutTarget) : bus.LutTarget;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = START_PC;
                sp_d    = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Control state, PC and status flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= START_PC;
            sp_q      <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            err_q     <= err_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    // Return-address storage; contents are meaningless above sp so no reset
    always_ff @(posedge Clk) begin
        if (push) begin
            stack_q[IDX_W'(sp_q)] <= pc_inc;
        end
    end
endmodule

// File: tb/tb_prog_ctr_seq.sv
// Bench for prog_ctr_seq: directed scenarios plus random traffic against a queue-based model.
module tb_prog_ctr_seq;
    localparam int unsigned D       = 12;
    localparam int unsigned STACK_D = 4;
    localparam int          NPC     = 4096;

    logic Clk = 1'b0;
    logic Reset_n;

    prog_ctr_seq_if #(.D(D)) bus ();

    prog_ctr_seq #(.D(D), .STACK_D(STACK_D), .START_PC(12'd0)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Branch-target LUT, combinational on the DUT's index output
    logic [D-1:0] lut [16];
    assign bus.LutTarget = lut[bus.LutAddr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_run, m_done, m_err;

    // Current stimulus
    bit         i_start, i_halt, i_stall, i_jump, i_rel, i_call, i_ret;
    logic [3:0] i_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit start, input bit halt, input bit stall, input bit jump,
                          input bit rel, input bit call, input bit ret, input logic [3:0] idx);
        i_start = start; i_halt = halt; i_stall = stall; i_jump = jump;
        i_rel = rel; i_call = call; i_ret = ret; i_idx = idx;
        bus.Start = start; bus.Halt = halt; bus.Stall = stall; bus.Jump = jump;
        bus.JumpRel = rel; bus.Call = call; bus.Ret = ret; bus.LutIdx = idx;
    endtask

    task automatic model_reset();
        m_pc = 0; m_stk.delete(); m_run = 0; m_done = 0; m_err = 0;
    endtask

    // One cycle of program-level behaviour
    task automatic model_step();
        int tgt;
        tgt = int'(lut[i_idx]);
        if (!m_run) begin
            if (i_start) begin
                m_run = 1; m_done = 0; m_pc = 0; m_stk.delete(); m_err = 0;
            end
        end else if (!i_stall) begin
            if (i_halt) begin
                m_run = 0; m_done = 1;
            end else if (i_ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_err = 1; m_pc = (m_pc + 1) % NPC; end
            end else if (i_call) begin
                if (m_stk.size() < STACK_D) m_stk.push_back((m_pc + 1) % NPC);
                else m_err = 1;
                m_pc = tgt;
            end else if (i_jump) begin
                m_pc = i_rel ? (m_pc + tgt) % NPC : tgt;
            end else begin
                m_pc = (m_pc + 1) % NPC;
            end
        end
    endtask

    task automatic compare_all();
        check("pc",      32'(bus.ProgCtr),  32'(m_pc));
        check("running", 32'(bus.Running),  32'(m_run));
        check("done",    32'(bus.Done),     32'(m_done));
        check("stackerr",32'(bus.StackErr), 32'(m_err));
        check("lutaddr", 32'(bus.LutAddr),  32'(i_idx));
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    // Drop reset between edges and confirm outputs clear without a clock
    task automatic mid_reset();
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_pc",      32'(bus.ProgCtr),  32'd0);
        check("rst_running", 32'(bus.Running),  32'd0);
        check("rst_done",    32'(bus.Done),     32'd0);
        check("rst_err",     32'(bus.StackErr), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 4'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = '0;
        lut[1] = 12'hFFF; lut[2] = 12'd4; lut[3] = 12'h014; lut[4] = 12'd2;
        lut[5] = 12'hFFB; lut[6] = 12'd10;
        lut[8] = 12'd100; lut[9] = 12'd200; lut[10] = 12'd300; lut[11] = 12'd400; lut[12] = 12'd500;
        set_in(0, 0, 0, 0, 0, 0, 0, 4'd0);
        Reset_n = 1'b0;
        model_reset();
        #12;
        check("reset_pc",      32'(bus.ProgCtr),  32'd0);
        check("reset_running", 32'(bus.Running),  32'd0);
        check("reset_done",    32'(bus.Done),     32'd0);
        check("reset_err",     32'(bus.StackErr), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // IDLE ignores branch controls
        set_in(0, 0, 0, 1, 0, 1, 0, 4'd6); tick();
        check("idle_hold", 32'(bus.ProgCtr), 32'd0);

        // Start then free-run
        set_in(1, 0, 0, 0, 0, 0, 0, 4'd0); tick();
        check("start_pc", 32'(bus.ProgCtr), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 4'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("freerun", 32'(bus.ProgCtr), 32'(i));
        end
        check("run_flag", 32'(bus.Running), 32'd1);

        // Absolute and relative jumps, including negative offsets and wrap
        set_in(0, 0, 0, 1, 0, 0, 0, 4'd2); tick();
        check("jabs", 32'(bus.ProgCtr), 32'd4);
        set_in(0, 0, 0, 1, 1, 0, 0, 4'd1); tick();
        check("jrel_neg1", 32'(bus.ProgCtr), 32'd3);
        set_in(0, 0, 0, 1, 1, 0, 0, 4'd3); tick();
        check("jrel_pos20", 32'(bus.ProgCtr), 32'd23);
        set_in(0, 0, 0, 1, 0, 0, 0, 4'd4); tick();
        set_in(0, 0, 0, 1, 1, 0, 0, 4'd5); tick();
        check("jrel_wrap", 32'(bus.ProgCtr), 32'd4093);
        set_in(0, 0, 0, 0, 0, 0, 0, 4'd0);
        tick(); tick(); tick();
        check("pc_wrap", 32'(bus.ProgCtr), 32'd0);

        // Call/return and empty-stack return
        set_in(0, 0, 0, 1, 0, 0, 0, 4'd6); tick();
        set_in(0, 0, 0, 1, 1, 1, 0, 4'd4); tick();
        check("call_pc", 32'(bus.ProgCtr), 32'd2);
        set_in(0, 0, 0, 0, 0, 0, 0, 4'd0);
        tick(); tick(); tick();
        check("pre_ret", 32'(bus.ProgCtr), 32'd5);
        set_in(0, 0, 0, 0, 0, 1, 1, 4'd4); tick();
        check("ret_pc", 32'(bus.ProgCtr), 32'd11);
        set_in(0, 0, 0, 0, 0, 0, 1, 4'd0); tick();
        check("ret_empty_pc", 32'(bus.ProgCtr), 32'd12);
        check("ret_empty_err", 32'(bus.StackErr), 32'd1);

        // Halt gated by stall, then DONE and restart
        set_in(0, 1, 1, 0, 0, 0, 0, 4'd0); tick();
        check("halt_stall_run", 32'(bus.Running), 32'd1);
        check("halt_stall_pc", 32'(bus.ProgCtr), 32'd12);
        set_in(0, 1, 0, 0, 0, 0, 0, 4'd0); tick();
        check("halt_done", 32'(bus.Done), 32'd1);
        check("halt_pc", 32'(bus.ProgCtr), 32'd12);
        set_in(0, 0, 0, 1, 0, 0, 0, 4'd2); tick();
        check("done_hold", 32'(bus.ProgCtr), 32'd12);
        set_in(1, 0, 0, 0, 0, 0, 0, 4'd0); tick();
        check("restart_pc", 32'(bus.ProgCtr), 32'd0);
        check("restart_err", 32'(bus.StackErr), 32'd0);

        // Overflow: fifth nested call still jumps, then LIFO returns
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 0, 4'(8 + i)); tick();
            check("nest_pc", 32'(bus.ProgCtr), 32'(100 * (i + 1)));
        end
        check("overflow_err", 32'(bus.StackErr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 4'd0); tick();
            check("lifo_ret", 32'(bus.ProgCtr), 32'(301 - 100 * i));
        end

        set_in(0, 0, 0, 0, 0, 0, 0, 4'd0); tick(); tick();
        mid_reset();

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) lut[$urandom_range(0, 15)] = D'($urandom);
            set_in($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                   $urandom_range(0, 5) == 0,  $urandom_range(0, 3) == 0,
                   1'($urandom),               $urandom_range(0, 5) == 0,
                   $urandom_range(0, 5) == 0,  4'($urandom));
            tick();
            if (c % 700 == 699) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
- Program counter sequencer for the 8-bit core's fetch stage.
- It owns the D-bit PC and drives the 4-bit index into the branch-target LUT. It consumes the returned target as either an absolute address or a signed relative offset.
- Adds start/halt control and a small hardware return-address stack for call/return. Feeds the instruction ROM address.

Parameters:
- D, 12, PC and LUT target width.
- STACK_D, 4, return-stack depth (entries, 1..8).
- START_PC, 0, PC value loaded on Start.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  launch program (accepted in IDLE or DONE).
- Halt  in  1  end program (from decoder).
- Stall  in  1  freeze PC and all state this cycle.
- Jump  in  1  taken branch using LUT target.
- JumpRel  in  1  1: target is signed offset; 0: absolute.
- Call  in  1  absolute jump via LUT, pushes return address.
- Ret  in  1  pop return address into PC.
- LutIdx  in  4  branch index field from instruction.
- LutAddr  out  4  index to branch-target LUT.
- LutTarget  in  D  LUT result, combinational response to LutAddr.
- ProgCtr  out  D  current PC.
- Running  out  1  state==RUN.
- Done  out  1  state==DONE.
- StackErr  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, Reset_n=0): state IDLE, ProgCtr=START_PC, stack pointer=0, stack contents don't-care, StackErr=0. Running and Done are 0.
- LutAddr = LutIdx, combinational. The LUT is a zero-latency lookup, so LutTarget is used in the same cycle.
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 -> RUN, ProgCtr=START_PC. Other inputs are ignored.
  - RUN: Start is ignored. On Halt=1 and Stall=0 -> DONE, ProgCtr holds.
  - DONE: Done=1, ProgCtr holds. Start=1 -> RUN, ProgCtr=START_PC, stack pointer=0, StackErr=0.
- RUN next-PC rules (one update per cycle, registered; ProgCtr changes on the edge after the control is sampled). Priority, highest first:
  - Stall: everything holds, including Halt and stack.
  - Halt: transition to DONE as above.
  - Ret:
    - If the stack is non-empty, pop: PC = top entry.
    - If empty: StackErr=1, PC = PC+1.
  - Call:
    - If not full, push PC+1 (mod 2^D) and set PC = LutTarget.
    - If full: StackErr=1, no push, PC = LutTarget (jump still taken).
    - JumpRel is ignored for Call.
  - Jump:
    - JumpRel=0: PC = LutTarget.
    - JumpRel=1: PC = (PC + LutTarget) mod 2^D, with LutTarget treated as D-bit two's complement.
  - Otherwise: PC = PC+1 mod 2^D; 2^D-1 wraps to 0.
- All PC arithmetic is D bits, with the carry discarded.
- Simultaneous Call+Ret resolves to Ret only. Simultaneous Jump+Call resolves to Call only.
- StackErr is sticky until reset or Start-from-DONE.
- Stack is LIFO. A push writes entry[sp] and increments sp; a pop decrements sp and reads entry[sp-1]. sp ranges 0..STACK_D.
- Reset asserted mid-RUN returns immediately to IDLE/START_PC; no partial stack state is retained.

Test Plan:
- Reset, Start pulse, 5 idle cycles -> ProgCtr 0,1,2,3,4,5. Running=1, Done=0.
- At PC=4, Jump=1, JumpRel=1, LutTarget=12'hFFF (-1) -> next PC=3. At PC=3, JumpRel=1, LutTarget=12'h014 (+20) -> 23.
- At PC=2, JumpRel=1, LutTarget=12'hFFB (-5) -> 4093 (wrap). Free-run from 4095 -> 0.
- Call at PC=10 with LutTarget=2 -> PC=2, pushes 11. Run 3 cycles to PC=5, then Ret -> PC=11. Then Ret on empty stack -> StackErr=1, PC=12.
- Five nested Calls with STACK_D=4 -> 5th Call jumps, StackErr=1. Four Rets then return addresses in LIFO order.
- Halt with Stall=1 -> stays RUN. Release Stall -> DONE with PC held. Start -> RUN at 0, StackErr cleared. Reset_n dropped mid-cycle -> outputs zero immediately.
